// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - byte-addressed CPU data memory with zero-fill init and selectable read latency
module data_mem_ctrl #(
   parameter int ADDR_W     = 8,
   parameter int RD_LAT     = 1,
   parameter int INIT_CLEAR = 1
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Req,
   input  logic              WE,
   input  logic [1:0]        Size,
   input  logic              Unsigned,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [31:0]       WData,
   output logic              Ready,
   output logic              RValid,
   output logic [31:0]       RData,
   output logic              Fault,
   output logic              InitDone
);

   localparam int IW    = ADDR_W - 2;
   localparam int DEPTH = 1 << IW;

   typedef enum logic {ST_INIT, ST_IDLE} state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] cnt, cnt_nxt;
   logic          init_we;
   logic          idle_st;

   logic [31:0]   mem [DEPTH];

   logic [IW-1:0] word_idx;
   logic [1:0]    off;
   logic          misalign;
   logic          accept;
   logic          load_acc;
   logic          wr_en;
   logic [3:0]    be;
   logic [31:0]   wd;
   logic [31:0]   rd_word;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   ld_data;

   // State and zero-fill counter; reset restarts the fill from word 0
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state <= (INIT_CLEAR != 0) ? ST_INIT : ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state: walk every word once in INIT, then park in IDLE for good
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      init_we   = 1'b0;
      idle_st   = 1'b0;
      case (state)
         ST_INIT: begin
            init_we = 1'b1;
            cnt_nxt = cnt + 1'b1;
            if (&cnt) state_nxt = ST_IDLE;
         end
         ST_IDLE: idle_st = 1'b1;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Rst gates Ready so that the no-clear build also reports not-ready during reset
   assign Ready    = idle_st & ~Rst;
   assign InitDone = idle_st & ~Rst;

   assign word_idx = Addr[ADDR_W-1:2];
   assign off      = Addr[1:0];
   assign misalign = (Size == 2'b11) |
                     ((Size == 2'b01) & Addr[0]) |
                     ((Size == 2'b10) & (off != 2'b00));
   assign accept   = Req & Ready;
   assign load_acc = accept & ~WE;
   assign wr_en    = accept & WE & ~misalign;

   // Byte-lane enables; store data is replicated so each lane sees its own slice
   always_comb begin
      be = 4'b0000;
      wd = 32'h0;
      case (Size)
         2'b00: begin
            be = 4'b0001 << off;
            wd = {4{WData[7:0]}};
         end
         2'b01: begin
            be = off[1] ? 4'b1100 : 4'b0011;
            wd = {2{WData[15:0]}};
         end
         default: begin
            be = 4'b1111;
            wd = WData;
         end
      endcase
   end

   // Array write port: zero-fill during INIT, lane-masked stores in IDLE
   always_ff @(posedge Clk) begin
      if (init_we) begin
         mem[cnt] <= 32'h0;
      end else if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[word_idx][8*b +: 8] <= wd[8*b +: 8];
         end
      end
   end

   assign rd_word  = mem[word_idx];
   assign byte_sel = rd_word[{off, 3'b000} +: 8];
   assign half_sel = off[1] ? rd_word[31:16] : rd_word[15:0];

   // Lane select and extension; a faulted load returns zero
   always_comb begin
      ld_data = 32'h0;
      if (!misalign) begin
         case (Size)
            2'b00:   ld_data = {{24{~Unsigned & byte_sel[7]}}, byte_sel};
            2'b01:   ld_data = {{16{~Unsigned & half_sel[15]}}, half_sel};
            default: ld_data = rd_word;
         endcase
      end
   end

   generate
      if (RD_LAT == 0) begin : g_comb
         assign RValid = load_acc;
         assign Fault  = accept & misalign;
         assign RData  = load_acc ? ld_data : 32'h0;
      end else begin : g_reg
         logic        rvalid_q;
         logic        fault_q;
         logic [31:0] rdata_q;

         // Registered response; reset drops any result still in flight
         always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
               rvalid_q <= 1'b0;
               fault_q  <= 1'b0;
               rdata_q  <= 32'h0;
            end else begin
               rvalid_q <= load_acc;
               fault_q  <= accept & misalign;
               if (load_acc) rdata_q <= ld_data;
            end
         end

         assign RValid = rvalid_q;
         assign Fault  = fault_q;
         assign RData  = rdata_q;
      end
   endgenerate

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - scoreboard bench for data_mem_ctrl in three parameter builds
module tb_data_mem_ctrl;

   typedef struct packed {
      logic        is_load;
      logic        fault;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, rst_c, req, req_c, we, uns;
   logic [1:0]  size;
   logic [7:0]  addr;
   logic [31:0] wdata;

   logic        ready_a, rvalid_a, fault_a, initdone_a;
   logic [31:0] rdata_a;
   logic        ready_b, rvalid_b, fault_b, initdone_b;
   logic [31:0] rdata_b;
   logic        ready_c, rvalid_c, fault_c, initdone_c;
   logic [31:0] rdata_c;

   exp_t qa[$], qb[$];
   int   pa[$], pb[$];
   exp_t ea, eb;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_mem_ctrl #(.ADDR_W(8), .RD_LAT(1), .INIT_CLEAR(1)) u_a (
      .Clk(clk), .Rst(rst), .Req(req), .WE(we), .Size(size), .Unsigned(uns),
      .Addr(addr), .WData(wdata), .Ready(ready_a), .RValid(rvalid_a),
      .RData(rdata_a), .Fault(fault_a), .InitDone(initdone_a));

   data_mem_ctrl #(.ADDR_W(8), .RD_LAT(0), .INIT_CLEAR(1)) u_b (
      .Clk(clk), .Rst(rst), .Req(req), .WE(we), .Size(size), .Unsigned(uns),
      .Addr(addr), .WData(wdata), .Ready(ready_b), .RValid(rvalid_b),
      .RData(rdata_b), .Fault(fault_b), .InitDone(initdone_b));

   data_mem_ctrl #(.ADDR_W(8), .RD_LAT(1), .INIT_CLEAR(0)) u_c (
      .Clk(clk), .Rst(rst_c), .Req(req_c), .WE(we), .Size(size), .Unsigned(uns),
      .Addr(addr), .WData(wdata), .Ready(ready_c), .RValid(rvalid_c),
      .RData(rdata_c), .Fault(fault_c), .InitDone(initdone_c));

   // Scoreboard: every RValid/Fault pulse consumes the oldest expectation
   always @(negedge clk) begin
      if (rvalid_a || fault_a) begin
         n_cmp++;
         if (qa.size() == 0) begin
            n_fail++;
            $display("FAIL sb_a unexpected pulse rv=%0b f=%0b d=%h", rvalid_a, fault_a, rdata_a);
         end else begin
            ea = qa.pop_front();
            pa.push_back(cyc);
            if (rvalid_a !== ea.is_load || fault_a !== ea.fault || (ea.is_load && rdata_a !== ea.data)) begin
               n_fail++;
               $display("FAIL sb_a got rv=%0b f=%0b d=%h want rv=%0b f=%0b d=%h",
                        rvalid_a, fault_a, rdata_a, ea.is_load, ea.fault, ea.data);
            end
         end
      end
      if (rvalid_b || fault_b) begin
         n_cmp++;
         if (qb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_b unexpected pulse rv=%0b f=%0b d=%h", rvalid_b, fault_b, rdata_b);
         end else begin
            eb = qb.pop_front();
            pb.push_back(cyc);
            if (rvalid_b !== eb.is_load || fault_b !== eb.fault || (eb.is_load && rdata_b !== eb.data)) begin
               n_fail++;
               $display("FAIL sb_b got rv=%0b f=%0b d=%h want rv=%0b f=%0b d=%h",
                        rvalid_b, fault_b, rdata_b, eb.is_load, eb.fault, eb.data);
            end
         end
      end
   end

   task automatic issue(input logic w, input logic [1:0] sz, input logic u, input logic [7:0] a,
                        input logic [31:0] wd, input logic ef, input logic [31:0] ed);
      exp_t e;
      req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
      if (!w || ef) begin
         e.is_load = ~w;
         e.fault   = ef;
         e.data    = ed;
         qa.push_back(e);
         qb.push_back(e);
      end
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      int n;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({ready_a, rvalid_a, fault_a, initdone_a} !== 4'b0000 || rdata_a !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_a got rdy=%0b rv=%0b f=%0b done=%0b d=%h want all zero",
                  ready_a, rvalid_a, fault_a, initdone_a, rdata_a);
      end
      n_cmp++;
      if (ready_c !== 1'b0 || rdata_c !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_c got rdy=%0b d=%h want 0/0", ready_c, rdata_c);
      end
      @(posedge clk); #1;
      rst = 1'b0; rst_c = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ready_c !== 1'b1 || initdone_c !== 1'b1) begin
         n_fail++;
         $display("FAIL noclear_ready got rdy=%0b done=%0b want 1/1", ready_c, initdone_c);
      end
      // Re-assert reset 30 cycles into the fill; the count restarts from deassertion
      repeat (29) @(posedge clk);
      #1;
      n_cmp++;
      if (ready_a !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_init_ready got %0b want 0", ready_a);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n = 0;
      while (n < 200) begin
         @(negedge clk);
         if (ready_a) break;
         n++;
      end
      n_cmp++;
      if (n !== 64) begin
         n_fail++;
         $display("FAIL init_cycles got %0d want 64", n);
      end
      n_cmp++;
      if (initdone_a !== 1'b1 || ready_b !== 1'b1 || initdone_b !== 1'b1) begin
         n_fail++;
         $display("FAIL init_done got a=%0b rdy_b=%0b done_b=%0b want 1/1/1", initdone_a, ready_b, initdone_b);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_zero_fill;
      issue(1'b0, 2'b10, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0);
      issue(1'b0, 2'b10, 1'b0, 8'h7C, 32'h0, 1'b0, 32'h0);
      issue(1'b0, 2'b10, 1'b0, 8'hFC, 32'h0, 1'b0, 32'h0);
      idle(3);
   endtask

   task automatic test_byte_half;
      issue(1'b1, 2'b10, 1'b0, 8'h10, 32'h80FF7F01, 1'b0, 32'h0);
      issue(1'b0, 2'b00, 1'b0, 8'h10, 32'h0, 1'b0, 32'h00000001);
      issue(1'b0, 2'b00, 1'b0, 8'h11, 32'h0, 1'b0, 32'h0000007F);
      issue(1'b0, 2'b00, 1'b0, 8'h12, 32'h0, 1'b0, 32'hFFFFFFFF);
      issue(1'b0, 2'b00, 1'b1, 8'h12, 32'h0, 1'b0, 32'h000000FF);
      issue(1'b0, 2'b00, 1'b0, 8'h13, 32'h0, 1'b0, 32'hFFFFFF80);
      issue(1'b0, 2'b01, 1'b0, 8'h12, 32'h0, 1'b0, 32'hFFFF80FF);
      issue(1'b0, 2'b01, 1'b1, 8'h12, 32'h0, 1'b0, 32'h000080FF);
      issue(1'b0, 2'b01, 1'b0, 8'h10, 32'h0, 1'b0, 32'h00007F01);
      issue(1'b0, 2'b10, 1'b1, 8'h10, 32'h0, 1'b0, 32'h80FF7F01);
      idle(3);
   endtask

   task automatic test_merge;
      issue(1'b1, 2'b10, 1'b0, 8'h20, 32'h11223344, 1'b0, 32'h0);
      issue(1'b1, 2'b00, 1'b0, 8'h21, 32'h555555AA, 1'b0, 32'h0);
      issue(1'b1, 2'b01, 1'b0, 8'h22, 32'h7777BEEF, 1'b0, 32'h0);
      issue(1'b0, 2'b10, 1'b0, 8'h20, 32'h0, 1'b0, 32'hBEEFAA44);
      idle(3);
   endtask

   task automatic test_fault;
      issue(1'b0, 2'b01, 1'b0, 8'h01, 32'h0, 1'b1, 32'h0);
      issue(1'b0, 2'b10, 1'b0, 8'h02, 32'h0, 1'b1, 32'h0);
      issue(1'b1, 2'b10, 1'b0, 8'h06, 32'hDEADBEEF, 1'b1, 32'h0);
      issue(1'b0, 2'b11, 1'b0, 8'h00, 32'h0, 1'b1, 32'h0);
      issue(1'b0, 2'b10, 1'b0, 8'h04, 32'h0, 1'b0, 32'h0);
      idle(3);
   endtask

   task automatic test_back_to_back;
      int t0;
      pa.delete();
      pb.delete();
      t0 = cyc;
      issue(1'b1, 2'b10, 1'b0, 8'h30, 32'hCAFEF00D, 1'b0, 32'h0);
      issue(1'b0, 2'b10, 1'b0, 8'h30, 32'h0, 1'b0, 32'hCAFEF00D);
      issue(1'b0, 2'b10, 1'b0, 8'h34, 32'h0, 1'b0, 32'h0);
      issue(1'b0, 2'b10, 1'b0, 8'h30, 32'h0, 1'b0, 32'hCAFEF00D);
      idle(3);
      n_cmp++;
      if (pa.size() != 3 || pb.size() != 3) begin
         n_fail++;
         $display("FAIL b2b_count got a=%0d b=%0d want 3/3", pa.size(), pb.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (pa[k] != t0 + k + 2 || pb[k] != t0 + k + 1) begin
               n_fail++;
               $display("FAIL b2b_timing[%0d] got a=%0d b=%0d want a=%0d b=%0d",
                        k, pa[k], pb[k], t0 + k + 2, t0 + k + 1);
            end
         end
      end
   endtask

   task automatic test_inflight_reset;
      logic seen;
      req_c = 1'b1; we = 1'b1; size = 2'b10; uns = 1'b0; addr = 8'h40; wdata = 32'h12345678;
      @(posedge clk); #1;
      we = 1'b0;
      @(posedge clk); #1;
      req_c = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (rvalid_c !== 1'b1 || rdata_c !== 32'h12345678) begin
         n_fail++;
         $display("FAIL noclear_load got rv=%0b d=%h want 1/12345678", rvalid_c, rdata_c);
      end
      @(posedge clk); #1;
      req_c = 1'b1;
      @(posedge clk); #1;
      rst_c = 1'b1;
      req_c = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (rvalid_c !== 1'b0 || rdata_c !== 32'h0 || ready_c !== 1'b0) begin
         n_fail++;
         $display("FAIL inflight_rst got rv=%0b d=%h rdy=%0b want 0/0/0", rvalid_c, rdata_c, ready_c);
      end
      @(posedge clk); #1;
      rst_c = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ready_c !== 1'b1 || initdone_c !== 1'b1) begin
         n_fail++;
         $display("FAIL post_rst_ready got rdy=%0b done=%0b want 1/1", ready_c, initdone_c);
      end
      seen = rvalid_c;
      repeat (4) begin
         @(negedge clk);
         seen = seen | rvalid_c;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL stale_result got rv_seen=%0b want 0", seen);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rst_c = 1'b1; req = 1'b0; req_c = 1'b0;
      we = 1'b0; size = 2'b10; uns = 1'b0; addr = 8'h00; wdata = 32'h0;
      test_reset;
      test_zero_fill;
      test_byte_half;
      test_merge;
      test_fault;
      test_back_to_back;
      test_inflight_reset;
      n_cmp++;
      if (qa.size() != 0 || qb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain got a=%0d b=%0d pending want 0/0", qa.size(), qb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised CPU data memory with byte-addressed load/store for LB/LBU/LH/LHU/LW/SB/SH/SW.
- Provides little-endian byte-lane writes, sign or zero extension on loads, and misalignment fault detection.
- Read latency is selectable: 0 (combinational) or 1 (registered).
- On reset, an FSM zero-fills the whole array before the block accepts requests.
- Sits between the MEM-stage pipeline register and the writeback mux.

Parameters:
- ADDR_W, 8, byte-address width. Depth is 2^(ADDR_W-2) 32-bit words. Legal range 3..16.
- RD_LAT, 1, read latency in cycles. Legal values 0 or 1.
- INIT_CLEAR, 1, enable the zero-fill sequence after reset. 1 = enabled, 0 = skip to IDLE.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Req  input  1  access request, qualified by Ready.
- WE  input  1  1 = store, 0 = load.
- Size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- Unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- Addr  input  ADDR_W  byte address.
- WData  input  32  store data, LSB-aligned (byte in [7:0], half in [15:0]).
- Ready  output  1  block can accept a request this cycle.
- RValid  output  1  load result valid.
- RData  output  32  load result, extended to 32 bits.
- Fault  output  1  one-cycle pulse: access was misaligned or Size illegal.
- InitDone  output  1  high once the zero-fill is complete; stays high until next reset.

Behaviour:
- States: INIT and IDLE.
- Reset (asynchronous, while Rst=1):
  - state = INIT if INIT_CLEAR=1, else IDLE; init counter = 0.
  - Ready=0, RValid=0, RData=0, Fault=0, InitDone=0.
  - Any pending registered read is discarded.
  - Array contents are not cleared by reset itself, only by INIT.
- INIT:
  - Each cycle writes 32'h0 to word[counter], then counter++.
  - After the last word (counter = 2^(ADDR_W-2)-1) is written, go to IDLE.
  - Takes exactly 2^(ADDR_W-2) cycles after Rst deasserts. Ready=0 throughout; Req is ignored.
  - Rst asserted mid-INIT restarts the sequence from word 0.
- IDLE: Ready=1 and InitDone=1. If INIT_CLEAR=0, InitDone=1 from the first cycle after reset.
- Accept = Req & Ready. One access per cycle; back-to-back accepts are allowed every cycle.
- Word index = Addr[ADDR_W-1:2]; byte offset = Addr[1:0].
- Misalignment: Fault is raised when any of these holds:
  - Size=01 and Addr[0]=1;
  - Size=10 and Addr[1:0]!=0;
  - Size=11.
- Faulted access:
  - No write occurs.
  - Fault pulses with the same latency as RValid.
  - A faulted load still produces RValid=1 with RData=0.
  - A faulted store pulses Fault only.
- Stores (accepted and aligned):
  - Byte: WData[7:0] goes to lane offset, using bits [8*off+7:8*off].
  - Half: WData[15:0] goes to lanes off and off+1, with off = 0 or 2.
  - Word: all four lanes.
  - Other lanes keep their value. The write commits at the accepting rising edge.
- Loads (accepted and aligned):
  - Select the lane(s) by offset and extend per Unsigned.
  - Word loads ignore Unsigned.
- Latency and pulse rules:
  - RD_LAT=0: RValid, RData and Fault are combinational in the accept cycle.
  - RD_LAT=1: RValid, RData and Fault are registered and valid in the cycle after accept.
  - RValid and Fault are single-cycle pulses per access. RData holds its last value when RValid=0 (RD_LAT=1) and is don't-care when RValid=0 (RD_LAT=0).
- Ordering:
  - A load accepted the cycle after a store to the same word returns the new data.
  - No simultaneous read/write hazard exists, because the block has a single access port.
- Out-of-range addresses cannot occur, since depth is derived from ADDR_W.

Test Plan:
- Reset then idle, ADDR_W=8, INIT_CLEAR=1 -> Ready=0 for exactly 64 cycles, then Ready=InitDone=1. LW from 0x00, 0x7C, 0xFC returns 0. Rst pulse at cycle 30 -> 64 fresh cycles counted from deassertion.
- SW 0x80FF7F01 @0x10, then LB/LBU/LH/LHU at 0x10..0x13 -> LB@0x10=0x00000001, LB@0x11=0x0000007F, LB@0x12=0xFFFFFFFF, LBU@0x12=0x000000FF, LH@0x12=0xFFFF80FF, LHU@0x12=0x000080FF, LW@0x10=0x80FF7F01.
- SW 0x11223344 @0x20, SB 0xAA @0x21, SH 0xBEEF @0x22 -> LW@0x20 = 0xBEEFAA44.
- Misaligned accesses: LH@0x01, LW@0x02, SW @0x06, Size=11 load @0x00 -> one Fault pulse each. Loads give RValid=1 with RData=0. LW@0x04 is unchanged after the faulted SW.
- Back-to-back accesses, RD_LAT=1: Req held 4 cycles with SW@0x30, LW@0x30, LW@0x34, LW@0x30 -> RValid high 3 consecutive cycles, one cycle after each load, with data matching. Repeat with RD_LAT=0 -> results appear in the accept cycle.
- INIT_CLEAR=0, plus Rst asserted during an in-flight RD_LAT=1 load -> Ready=1 in the first post-reset cycle; RValid stays 0 and the pending result never appears.
